// File: rtl/arith_pkg.sv
// Shared types for the arith_engine block: operation codes, FSM states and
// the per-operation iteration count.
package arith_pkg;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_SQRT = 2'b01,
        OP_MUL  = 2'b10,
        OP_RSV  = 2'b11
    } opcode_e;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StCalc,
        StDone
    } state_e;

    // Root extraction retires two radicand bits per step, so it needs half the steps.
    function automatic int unsigned calc_iters(input opcode_e op, input int unsigned w);
        return (op == OP_SQRT) ? w / 2 : w;
    endfunction

endpackage

// File: rtl/iteration_counter.sv
// Counts CALC cycles up to a loadable terminal count; last flags the final iteration.
module iteration_counter #(
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] term,
    output logic             last
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] term_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
            term_q  <= '0;
        end else if (load) begin
            count_q <= '0;
            term_q  <= term;
        end else if (en) begin
            count_q <= count_q + CNT_W'(1);
        end
    end

    assign last = (count_q == term_q - CNT_W'(1));

endmodule

// File: rtl/arith_engine.sv
// Sequential multiply / divide / square-root engine with sign-magnitude operands.
// Define ARITH_ENGINE_SQRT_EN to build the square-root datapath; otherwise opcode 01 is illegal.
module arith_engine
    import arith_pkg::*;
#(
    parameter int unsigned WORD_LENGHT = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [1:0]                 opCode,
    input  logic [WORD_LENGHT-1:0]     operand_1,
    input  logic [WORD_LENGHT-1:0]     operand_2,
    input  logic                       sign_1,
    input  logic                       sign_2,
    output logic [2*WORD_LENGHT-1:0]   result,
    output logic                       result_sign,
    output logic [WORD_LENGHT-1:0]     remainder,
    output logic                       busy,
    output logic                       done,
    output logic                       error
);

    localparam int unsigned W  = WORD_LENGHT;
    localparam int unsigned CW = $clog2(W + 1);

    state_e         state_q;
    opcode_e        op_q;
    logic [W-1:0]   a_q, b_q;
    logic           s1_q, s2_q;

    // Multiply: {accumulator, multiplier} shifted right once per step.
    logic [2*W:0]   mul_q, mul_nxt;
    logic [W:0]     mul_sum;
    // Restoring divide: partial remainder and quotient/dividend shift register.
    logic [W-1:0]   div_rem_q, div_rem_nxt;
    logic [W-1:0]   div_quo_q, div_quo_nxt;
    logic [W:0]     div_sh;
`ifdef ARITH_ENGINE_SQRT_EN
    logic [W-1:0]   sq_rad_q, sq_rem_q, sq_root_q;
    logic [W-1:0]   sq_rem_nxt, sq_root_nxt;
    logic [W+1:0]   sq_sh, sq_trial;
`endif

    logic [2*W-1:0] fin_res;
    logic [W-1:0]   fin_rem;
    logic           fin_sign;
    logic           op_illegal;
    logic           iter_last;

    iteration_counter #(
        .CNT_W(CW)
    ) u_iter_cnt (
        .clk (clk),
        .rst (rst),
        .load(state_q == StLoad),
        .en  (state_q == StCalc),
        .term(CW'(calc_iters(op_q, W))),
        .last(iter_last)
    );

    always_comb begin
        mul_sum = mul_q[2*W:W] + (mul_q[0] ? {1'b0, a_q} : '0);
        mul_nxt = {1'b0, mul_sum, mul_q[W-1:1]};

        div_sh = {div_rem_q, div_quo_q[W-1]};
        if (div_sh >= {1'b0, b_q}) begin
            div_rem_nxt = W'(div_sh - {1'b0, b_q});
            div_quo_nxt = {div_quo_q[W-2:0], 1'b1};
        end else begin
            div_rem_nxt = div_sh[W-1:0];
            div_quo_nxt = {div_quo_q[W-2:0], 1'b0};
        end

`ifdef ARITH_ENGINE_SQRT_EN
        sq_sh    = {sq_rem_q, sq_rad_q[W-1:W-2]};
        sq_trial = {sq_root_q, 2'b01};
        if (sq_sh >= sq_trial) begin
            sq_rem_nxt  = W'(sq_sh - sq_trial);
            sq_root_nxt = {sq_root_q[W-2:0], 1'b1};
        end else begin
            sq_rem_nxt  = W'(sq_sh);
            sq_root_nxt = {sq_root_q[W-2:0], 1'b0};
        end
`endif

        fin_res = '0;
        fin_rem = '0;
        case (op_q)
            OP_MUL: fin_res = mul_nxt[2*W-1:0];
            OP_DIV: begin
                fin_res = {{W{1'b0}}, div_quo_nxt};
                fin_rem = div_rem_nxt;
            end
`ifdef ARITH_ENGINE_SQRT_EN
            OP_SQRT: begin
                fin_res = {{W{1'b0}}, sq_root_nxt};
                fin_rem = sq_rem_nxt;
            end
`endif
            default: ;
        endcase
        fin_sign = (op_q != OP_SQRT) && (s1_q ^ s2_q) && (fin_res != '0);

`ifdef ARITH_ENGINE_SQRT_EN
        op_illegal = (op_q == OP_RSV) || ((op_q == OP_DIV) && (b_q == '0)) ||
                     ((op_q == OP_SQRT) && s1_q);
`else
        op_illegal = (op_q == OP_RSV) || ((op_q == OP_DIV) && (b_q == '0)) ||
                     (op_q == OP_SQRT);
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            op_q        <= OP_DIV;
            a_q         <= '0;
            b_q         <= '0;
            s1_q        <= 1'b0;
            s2_q        <= 1'b0;
            mul_q       <= '0;
            div_rem_q   <= '0;
            div_quo_q   <= '0;
`ifdef ARITH_ENGINE_SQRT_EN
            sq_rad_q    <= '0;
            sq_rem_q    <= '0;
            sq_root_q   <= '0;
`endif
            result      <= '0;
            remainder   <= '0;
            result_sign <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        op_q    <= opcode_e'(opCode);
                        a_q     <= operand_1;
                        b_q     <= operand_2;
                        s1_q    <= sign_1;
                        s2_q    <= sign_2;
                        error   <= 1'b0;
                        busy    <= 1'b1;
                        state_q <= StLoad;
                    end
                end
                StLoad: begin
                    mul_q     <= {{(W + 1){1'b0}}, b_q};
                    div_rem_q <= '0;
                    div_quo_q <= a_q;
`ifdef ARITH_ENGINE_SQRT_EN
                    sq_rad_q  <= a_q;
                    sq_rem_q  <= '0;
                    sq_root_q <= '0;
`endif
                    if (op_illegal) begin
                        result      <= '0;
                        remainder   <= '0;
                        result_sign <= 1'b0;
                        error       <= 1'b1;
                        done        <= 1'b1;
                        state_q     <= StDone;
                    end else begin
                        state_q <= StCalc;
                    end
                end
                StCalc: begin
                    mul_q     <= mul_nxt;
                    div_rem_q <= div_rem_nxt;
                    div_quo_q <= div_quo_nxt;
`ifdef ARITH_ENGINE_SQRT_EN
                    sq_rad_q  <= {sq_rad_q[W-3:0], 2'b00};
                    sq_rem_q  <= sq_rem_nxt;
                    sq_root_q <= sq_root_nxt;
`endif
                    // Commit the final step's values directly so outputs change only on DONE entry.
                    if (iter_last) begin
                        result      <= fin_res;
                        remainder   <= fin_rem;
                        result_sign <= fin_sign;
                        done        <= 1'b1;
                        state_q     <= StDone;
                    end
                end
                StDone: begin
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/arith_engine.md
ARITH_ENGINE -- requirements
Module: arith_engine

Interface
- REQ-001 SHALL have parameter WORD_LENGHT, default 8, giving the operand magnitude width; even, >= 4.
- REQ-002 SHALL have clk  input  1  the single clock; all state updates on its rising edge.
- REQ-003 SHALL have rst  input  1  reset, synchronous and active-high.
- REQ-004 SHALL have start  input  1  one-cycle command pulse from the input stage.
- REQ-005 SHALL have opCode  input  2  operation: 00 divide, 01 square root, 10 multiply, 11 reserved.
- REQ-006 SHALL have operand_1 / operand_2  input  WORD_LENGHT each  unsigned magnitudes.
- REQ-007 SHALL have sign_1 / sign_2  input  1 each  operand signs, 1 = negative.
- REQ-008 SHALL have result  output  2*WORD_LENGHT  product, quotient or root magnitude, zero-extended.
- REQ-009 SHALL have result_sign  output  1  sign of result.
- REQ-010 SHALL have remainder  output  WORD_LENGHT  division remainder or root residue.
- REQ-011 SHALL have busy, done, error  output  1 each  operation in progress / one-cycle completion pulse / illegal operation flag.

Function
- REQ-012 SHALL implement FSM IDLE -> LOAD -> CALC -> DONE -> IDLE.
- REQ-013 In IDLE, start=1 SHALL latch opCode, operands and signs at that edge and move to LOAD.
- REQ-014 start SHALL be ignored in every state except IDLE.
- REQ-015 LOAD SHALL evaluate error: opCode 00 with operand_2==0, opCode 01 with sign_1==1, or opCode 11; on error go straight to DONE, else to CALC.
- REQ-016 CALC SHALL run N iterations, one per cycle: N=WORD_LENGHT for multiply (shift-add) and divide (restoring), N=WORD_LENGHT/2 for square root (digit-by-digit).
- REQ-017 done SHALL be high for exactly one cycle in DONE, N+2 edges after the edge sampling start (2 edges on error).
- REQ-018 busy SHALL be 1 in LOAD, CALC and DONE, and 0 in IDLE.
- REQ-019 Multiply: result = operand_1*operand_2, remainder = 0.
- REQ-020 Divide: result = floor(operand_1/operand_2), remainder = operand_1 mod operand_2.
- REQ-021 Square root: result = floor(sqrt(operand_1)), remainder = operand_1 - result^2.
- REQ-022 result_sign SHALL be sign_1^sign_2 for multiply/divide and 0 for square root; forced 0 when result==0.
- REQ-023 On error, result, remainder and result_sign SHALL be 0 and error=1.
- REQ-024 result, remainder, result_sign and error SHALL update only on entry to DONE and hold until the next accepted start, which clears error.
- REQ-025 Operands of all-ones magnitude SHALL produce exact results without overflow (product fits 2*WORD_LENGHT).

Reset
- REQ-026 rst=1 at an edge SHALL force IDLE; result, remainder, result_sign, busy, done and error all 0.
- REQ-027 rst during LOAD/CALC/DONE SHALL abort the operation with no done pulse; rst has priority over start.

Configuration
- REQ-028 Macro ARITH_ENGINE_SQRT_EN defined: square root datapath compiled in per REQ-021.
- REQ-029 ARITH_ENGINE_SQRT_EN undefined: no root datapath; opCode 01 SHALL be treated as illegal (error=1, done after 2 edges).

Structure
- REQ-030 Package arith_pkg SHALL hold the opcode enum (OP_DIV, OP_SQRT, OP_MUL, OP_RSV) and the FSM state enum.
- REQ-031 Sub-module iteration_counter SHALL count CALC cycles with loadable terminal count N and a last-iteration flag.

Verification (WORD_LENGHT=8)
- REQ-032 multiply 12 (+) by 5 (-) -> result 60, result_sign 1, done 10 edges after start.
- REQ-033 divide 100 by 7 -> result 14, remainder 2, error 0, done 10 edges after start.
- REQ-034 divide 55 by 0 -> error 1, result 0, done 2 edges after start; next valid start clears error.
- REQ-035 sqrt 200 -> result 14, remainder 4, done 6 edges after start; sqrt of 3 (-) -> error 1.
- REQ-036 multiply 255 by 255 -> result 65025; second start pulse during CALC ignored, exactly one done.
- REQ-037 rst at CALC iteration 3 -> next cycle busy 0, outputs 0, no done pulse; new start then completes normally.
